// File: rtl/taiga_types.sv
// Shared types and constants for the L1 port arbiter and the blocks around it.
package taiga_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        READ_WAIT = 2'd2
    } l1_arb_state_t;

    localparam int L1_BEAT_W = 32;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first set request at or after i_rr_ptr,
// wrapping around, returned as a one-hot grant.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_request,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_sel;

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign w_mask[gi] = (PTR_W'(gi) >= i_rr_ptr);
        end
    endgenerate

    assign w_upper = i_request & w_mask;
    assign w_sel   = (|w_upper) ? w_upper : i_request;
    assign o_grant = w_sel & (~w_sel + NUM_REQ'(1));
    assign o_valid = |i_request;

endmodule

// File: rtl/l1_rr_arbiter.sv
// Round-robin owner of the single L1 memory port; a read keeps ownership until
// its final return beat so every burst is steered back to its issuer.
module l1_rr_arbiter
    import taiga_types::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST_W = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    i_req_request,
    input  logic [NUM_REQ-1:0][31:0]              i_req_addr,
    input  logic [NUM_REQ-1:0][31:0]              i_req_data,
    input  logic [NUM_REQ-1:0]                    i_req_rnw,
    input  logic [NUM_REQ-1:0][3:0]               i_req_be,
    input  logic [NUM_REQ-1:0][MAX_BURST_W-1:0]   i_req_size,
    output logic [NUM_REQ-1:0]                    o_req_ack,
    output logic [L1_BEAT_W-1:0]                  o_rsp_data,
    output logic [NUM_REQ-1:0]                    o_rsp_data_valid,
    output logic                                  o_mem_request,
    output logic [31:0]                           o_mem_addr,
    output logic [31:0]                           o_mem_data,
    output logic                                  o_mem_rnw,
    output logic [3:0]                            o_mem_be,
    output logic [MAX_BURST_W-1:0]                o_mem_size,
    input  logic                                  i_mem_ack,
    input  logic [L1_BEAT_W-1:0]                  i_mem_rdata,
    input  logic                                  i_mem_rdata_valid,
    output logic [NUM_REQ-1:0]                    o_owner,
    output logic                                  o_spurious_beat
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    l1_arb_state_t          r_state;
    logic [NUM_REQ-1:0]     r_owner;
    logic [PTR_W-1:0]       r_owner_idx;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [MAX_BURST_W-1:0] r_beat_cnt;
    logic                   r_spurious;

    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_grant_valid;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_issue_live;
    logic                   w_accept;
    logic                   w_reading;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .i_request (i_req_request),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_grant),
        .o_valid   (w_grant_valid)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    assign w_next_ptr = (r_owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner_idx + PTR_W'(1);

    // A dropped request in ISSUE is an abort and must never be acked, even if
    // memory raises mem_ack in the same cycle.
    assign w_issue_live = (r_state == ISSUE) && i_req_request[r_owner_idx];
    assign w_accept     = w_issue_live && i_mem_ack;
    assign w_reading    = (r_state == READ_WAIT);

    assign o_mem_request = w_issue_live;
    assign o_mem_addr    = i_req_addr[r_owner_idx];
    assign o_mem_data    = i_req_data[r_owner_idx];
    assign o_mem_rnw     = i_req_rnw[r_owner_idx];
    assign o_mem_be      = i_req_be[r_owner_idx];
    assign o_mem_size    = i_req_rnw[r_owner_idx] ? i_req_size[r_owner_idx] : '0;

    assign o_req_ack        = w_accept ? r_owner : '0;
    assign o_rsp_data       = i_mem_rdata;
    assign o_rsp_data_valid = (w_reading && i_mem_rdata_valid) ? r_owner : '0;
    assign o_owner          = r_owner;
    assign o_spurious_beat  = r_spurious;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_owner_idx <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_spurious  <= 1'b0;
        end else begin
            // Beats outside READ_WAIT (including one sharing the ack cycle) are dropped.
            if (i_mem_rdata_valid && !w_reading) begin
                r_spurious <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant;
                        r_owner_idx <= w_grant_idx;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_req_request[r_owner_idx]) begin
                        r_owner <= '0;
                        r_state <= IDLE;
                    end else if (i_mem_ack) begin
                        r_rr_ptr <= w_next_ptr;
                        if (i_req_rnw[r_owner_idx]) begin
                            r_beat_cnt <= i_req_size[r_owner_idx];
                            r_state    <= READ_WAIT;
                        end else begin
                            r_owner <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                READ_WAIT: begin
                    if (i_mem_rdata_valid) begin
                        if (r_beat_cnt == '0) begin
                            r_owner <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - MAX_BURST_W'(1);
                        end
                    end
                end
                default: begin
                    r_owner <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
